// File: rtl/mat_diag_streamer_if.sv
`default_nettype none
// ============================================================================
// Module   : mat_diag_streamer_if
// Brief    : Cache diagonal-read port plus the valid/ready vector stream
//            between mat_diag_streamer, the matrix cache and the systolic unit.
// Revision : 1.0 - initial release
// ============================================================================
interface mat_diag_streamer_if #(
    parameter int WIDTH           = 128,
    parameter int WIDTH_ADDR_SIZE = 1 + $clog2(WIDTH),
    parameter int CACHE_SIZE      = 4,
    parameter int CACHE_ADDR_SIZE = $clog2(CACHE_SIZE)
);
    typedef enum logic [1:0] {
        MAT_CACHE_READ_ROW  = 2'd0,
        MAT_CACHE_READ_COL  = 2'd1,
        MAT_CACHE_READ_DIAG = 2'd2
    } MatCacheReadOp_t;

    // Lanes carry IEEE-754 single-precision encodings; 0.0 is all-zero bits.
    logic                       read_enable;
    MatCacheReadOp_t            read_type;
    logic [CACHE_ADDR_SIZE-1:0] read_addr1;
    logic [CACHE_ADDR_SIZE-1:0] read_addr2;
    logic [WIDTH_ADDR_SIZE-1:0] read_param;
    logic [31:0]                cache_data [WIDTH];
    logic [31:0]                out_data   [WIDTH];
    logic                       out_valid;
    logic                       out_ready;
    logic                       out_last;

    assign read_type = MAT_CACHE_READ_DIAG;

    modport master (
        output read_enable, read_addr1, read_addr2, read_param,
        output out_data, out_valid, out_last,
        input  cache_data, out_ready
    );

    modport slave (
        input  read_enable, read_type, read_addr1, read_addr2, read_param,
        input  out_data, out_valid, out_last,
        output cache_data, out_ready
    );
endinterface
`default_nettype wire

// File: rtl/mat_diag_streamer.sv
`default_nettype none
// ============================================================================
// Module   : mat_diag_streamer
// Brief    : Walks the cache diagonal read mode over N cached matrices and
//            streams masked, skewed anti-diagonal vectors over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module mat_diag_streamer #(
    parameter int WIDTH           = 128,
    parameter int WIDTH_ADDR_SIZE = 1 + $clog2(WIDTH),
    parameter int CACHE_SIZE      = 4,
    parameter int CACHE_ADDR_SIZE = $clog2(CACHE_SIZE)
) (
    input  wire logic                       clock,
    input  wire logic                       reset,
    input  wire logic                       start,
    input  wire logic [CACHE_ADDR_SIZE-1:0] base_addr,
    input  wire logic [CACHE_ADDR_SIZE:0]   count,
    output logic                            busy,
    output logic                            done,
    mat_diag_streamer_if.master             bus
);
    localparam int c_P_BITS = $clog2(WIDTH);
    localparam logic [c_P_BITS-1:0]        c_P_LAST     = c_P_BITS'(WIDTH - 1);
    localparam logic [CACHE_ADDR_SIZE:0]   c_CACHE_EXT  = (CACHE_ADDR_SIZE + 1)'(CACHE_SIZE);
    localparam logic [CACHE_ADDR_SIZE-1:0] c_LAST_SLOT  = CACHE_ADDR_SIZE'(CACHE_SIZE - 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_STREAM = 2'd1;
    localparam logic [1:0] c_DRAIN  = 2'd2;

    logic [1:0]                 r_state;
    logic [1:0]                 w_state_next;
    logic [CACHE_ADDR_SIZE-1:0] r_base;
    logic [CACHE_ADDR_SIZE:0]   r_count;
    logic [CACHE_ADDR_SIZE:0]   r_n;
    logic [c_P_BITS-1:0]        r_p;
    logic [31:0]                r_out_data [WIDTH];
    logic                       r_out_valid;
    logic                       r_out_last;
    logic                       r_done;

    logic                       w_advance;
    logic                       w_read_enable;
    logic                       w_busy;
    logic                       w_first_n;
    logic                       w_final_n;
    logic                       w_last_read;
    logic                       w_last_hs;
    logic [WIDTH-1:0]           w_lane_zero;
    logic [CACHE_ADDR_SIZE:0]   w_sum1;
    logic [CACHE_ADDR_SIZE:0]   w_addr1_ext;
    logic [CACHE_ADDR_SIZE-1:0] w_addr1;
    logic [CACHE_ADDR_SIZE-1:0] w_addr2;

    assign w_advance   = !r_out_valid || bus.out_ready;
    assign w_first_n   = (r_n == '0);
    assign w_final_n   = (r_n == r_count);
    assign w_last_read = w_final_n && (r_p == c_P_LAST);
    assign w_last_hs   = r_out_valid && bus.out_ready && r_out_last;

    // base+n never exceeds 2*CACHE_SIZE-1, so a single conditional subtract wraps it.
    assign w_sum1      = {1'b0, r_base} + r_n;
    assign w_addr1_ext = (w_sum1 >= c_CACHE_EXT) ? (w_sum1 - c_CACHE_EXT) : w_sum1;
    assign w_addr1     = w_addr1_ext[CACHE_ADDR_SIZE-1:0];
    assign w_addr2     = (w_addr1 == '0) ? c_LAST_SLOT : (w_addr1 - CACHE_ADDR_SIZE'(1));

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:   if (start && (count != '0)) w_state_next = c_STREAM;
            c_STREAM: if (w_advance && w_last_read) w_state_next = c_DRAIN;
            c_DRAIN:  if (w_last_hs) w_state_next = c_IDLE;
            default:  w_state_next = c_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        w_busy        = (r_state != c_IDLE);
        w_read_enable = (r_state == c_STREAM) && w_advance;
    end

    // Lanes with no source matrix: the trailing skew of the last diagonal
    // row-set and the leading skew of the first.
    always_comb begin
        w_lane_zero = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_lane_zero[i] = ((c_P_BITS'(i) <= r_p) && w_final_n) ||
                             ((c_P_BITS'(i) >  r_p) && w_first_n);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_base      <= '0;
            r_count     <= '0;
            r_n         <= '0;
            r_p         <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                r_out_data[i] <= 32'h0;
            end
        end else begin
            r_done <= 1'b0;
            if ((r_state == c_IDLE) && start) begin
                r_base  <= base_addr;
                r_count <= count;
                r_n     <= '0;
                r_p     <= '0;
                if (count == '0) begin
                    r_done <= 1'b1;
                end
            end
            if (w_read_enable) begin
                for (int i = 0; i < WIDTH; i++) begin
                    r_out_data[i] <= w_lane_zero[i] ? 32'h0 : bus.cache_data[i];
                end
                r_out_valid <= 1'b1;
                r_out_last  <= w_last_read;
                if (r_p == c_P_LAST) begin
                    r_p <= '0;
                    r_n <= r_n + (CACHE_ADDR_SIZE + 1)'(1);
                end else begin
                    r_p <= r_p + c_P_BITS'(1);
                end
            end else if ((r_state != c_STREAM) && bus.out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
            if ((r_state == c_DRAIN) && w_last_hs) begin
                r_done <= 1'b1;
            end
        end
    end

    assign busy            = w_busy;
    assign done            = r_done;
    assign bus.read_enable = w_read_enable;
    assign bus.read_addr1  = w_addr1;
    assign bus.read_addr2  = w_addr2;
    assign bus.read_param  = WIDTH_ADDR_SIZE'(r_p);
    assign bus.out_data    = r_out_data;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_last    = r_out_last;
endmodule
`default_nettype wire

// File: tb/tb_mat_diag_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mat_diag_streamer
// Brief    : Directed self-checking bench for mat_diag_streamer (WIDTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mat_diag_streamer;
    localparam int c_WIDTH = 4;
    localparam int c_CS    = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] base_addr;
    logic [2:0] count;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    mat_diag_streamer_if #(.WIDTH(c_WIDTH), .CACHE_SIZE(c_CS)) bus ();

    mat_diag_streamer #(.WIDTH(c_WIDTH), .CACHE_SIZE(c_CS)) dut (
        .clock     (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] i2f(input int v);
        int e;
        logic [31:0] m;
        if (v <= 0) return 32'h0;
        e = 0;
        for (int b = 0; b < 30; b++) if (v >= (1 << b)) e = b;
        m = 32'(v) << (23 - e);
        return {1'b0, 8'(e + 127), m[22:0]};
    endfunction

    function automatic logic [127:0] exp_vec(input int a, input int b, input int c, input int d);
        return {i2f(d), i2f(c), i2f(b), i2f(a)};
    endfunction

    function automatic logic [127:0] out_vec();
        logic [127:0] v;
        for (int i = 0; i < c_WIDTH; i++) v[32*i +: 32] = bus.out_data[i];
        return v;
    endfunction

    // Cache model: slot s holds M_s[i][j] = 100*s + 10*i + j, diagonal read mode.
    always_comb begin
        for (int i = 0; i < c_WIDTH; i++) begin
            if (i <= int'(bus.read_param))
                bus.cache_data[i] = i2f(100 * int'(bus.read_addr1) + 10 * i + int'(bus.read_param) - i);
            else
                bus.cache_data[i] = i2f(100 * int'(bus.read_addr2) + 10 * i + c_WIDTH + int'(bus.read_param) - i);
        end
    end

    int gold1 [8][4] = '{
        '{0, 0, 0, 0}, '{1, 10, 0, 0}, '{2, 11, 20, 0}, '{3, 12, 21, 30},
        '{0, 13, 22, 31}, '{0, 0, 23, 32}, '{0, 0, 0, 33}, '{0, 0, 0, 0}
    };
    int gold2 [12][4] = '{
        '{300, 0, 0, 0}, '{301, 310, 0, 0}, '{302, 311, 320, 0}, '{303, 312, 321, 330},
        '{0, 313, 322, 331}, '{1, 10, 323, 332}, '{2, 11, 20, 333}, '{3, 12, 21, 30},
        '{0, 13, 22, 31}, '{0, 0, 23, 32}, '{0, 0, 0, 33}, '{0, 0, 0, 0}
    };

    logic [127:0] beats [$];
    bit           lasts [$];
    logic [1:0]   addr1_q [$];
    logic [1:0]   addr2_q [$];
    int first_valid_k, first_read_k, done_k, done_cnt, last_hs_k, stall_viol;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] beat_at(input int k);
        return (k < beats.size()) ? beats[k] : 128'bx;
    endfunction

    function automatic logic [15:0] last_mask();
        logic [15:0] m;
        m = '0;
        for (int i = 0; i < lasts.size() && i < 16; i++) m[i] = lasts[i];
        return m;
    endfunction

    // ready_mode 0: always ready; 1: ready pattern 1,0,0,1 repeating.
    task automatic run_job(input logic [1:0] b, input logic [2:0] c, input int ready_mode, input bit hold_start);
        logic [127:0] prev;
        bit prev_stall;
        bit seen_last;
        beats.delete(); lasts.delete(); addr1_q.delete(); addr2_q.delete();
        first_valid_k = -1; first_read_k = -1; done_k = -1; done_cnt = 0;
        last_hs_k = -1; stall_viol = 0;
        prev = '0; prev_stall = 1'b0; seen_last = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            start         = (k == 0) || (hold_start && !seen_last);
            base_addr     = b;
            count         = c;
            bus.out_ready = (ready_mode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
            #1;
            if (prev_stall && (!bus.out_valid || (out_vec() !== prev))) stall_viol++;
            if (bus.out_valid && !bus.out_ready && bus.read_enable) stall_viol++;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev       = out_vec();
            if (bus.read_enable && first_read_k < 0) first_read_k = k;
            if (bus.read_enable && (bus.read_param == '0)) begin
                addr1_q.push_back(bus.read_addr1);
                addr2_q.push_back(bus.read_addr2);
            end
            if (bus.out_valid && first_valid_k < 0) first_valid_k = k;
            if (bus.out_valid && bus.out_ready) begin
                beats.push_back(out_vec());
                lasts.push_back(bus.out_last);
                if (bus.out_last) begin
                    seen_last = 1'b1;
                    last_hs_k = k;
                end
            end
            if (done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if ((done_k >= 0) && (k >= done_k + 6)) break;
        end
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; count = '0; bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy",   busy,            1'b0);
        check("rst_done",   done,            1'b0);
        check("rst_valid",  bus.out_valid,   1'b0);
        check("rst_last",   bus.out_last,    1'b0);
        check("rst_rden",   bus.read_enable, 1'b0);
        check("rst_data",   out_vec(),       128'h0);
        @(negedge clk);
        reset = 1'b0;

        // Single matrix, consumer always ready
        run_job(2'd0, 3'd1, 0, 1'b0);
        check("a_first_read",  first_read_k,  1);
        check("a_first_valid", first_valid_k, 2);
        check("a_beats",       beats.size(),  8);
        for (int k = 0; k < 8; k++)
            check($sformatf("a_beat%0d", k), beat_at(k), exp_vec(gold1[k][0], gold1[k][1], gold1[k][2], gold1[k][3]));
        check("a_last_mask", last_mask(), 16'h0080);
        check("a_done_k",    done_k,      10);
        check("a_done_cnt",  done_cnt,    1);
        check("a_busy_end",  busy,        1'b0);
        check("a_read_type", bus.read_type, 2'd2);

        // Two matrices wrapping around the cache
        run_job(2'd3, 3'd2, 0, 1'b0);
        check("b_beats", beats.size(), 12);
        for (int k = 0; k < 12; k++)
            check($sformatf("b_beat%0d", k), beat_at(k), exp_vec(gold2[k][0], gold2[k][1], gold2[k][2], gold2[k][3]));
        check("b_addr1", (addr1_q.size() == 3) ? {addr1_q[0], addr1_q[1], addr1_q[2]} : 6'bx, {2'd3, 2'd0, 2'd1});
        check("b_addr2", (addr2_q.size() == 3) ? {addr2_q[0], addr2_q[1], addr2_q[2]} : 6'bx, {2'd2, 2'd3, 2'd0});
        check("b_last_mask", last_mask(), 16'h0800);

        // Backpressure pattern 1,0,0,1
        run_job(2'd0, 3'd1, 1, 1'b0);
        check("c_beats", beats.size(), 8);
        for (int k = 0; k < 8; k++)
            check($sformatf("c_beat%0d", k), beat_at(k), exp_vec(gold1[k][0], gold1[k][1], gold1[k][2], gold1[k][3]));
        check("c_stall_hold", stall_viol, 0);
        check("c_done_cnt",   done_cnt,   1);
        check("c_done_after_last", done_k, last_hs_k + 1);

        // Zero-length job
        @(negedge clk);
        start = 1'b1; count = 3'd0; base_addr = 2'd1; bus.out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("z_done",  done,          1'b1);
        check("z_busy",  busy,          1'b0);
        check("z_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        #1;
        check("z_done_off", done,          1'b0);
        check("z_valid2",   bus.out_valid, 1'b0);

        // Reset mid-stream with beat 3 held
        @(negedge clk);
        start = 1'b1; count = 3'd1; base_addr = 2'd0; bus.out_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        #1;
        check("r_held_valid", bus.out_valid, 1'b1);
        check("r_held_beat3", out_vec(), exp_vec(2, 11, 20, 0));
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("r_valid", bus.out_valid, 1'b0);
        check("r_busy",  busy,          1'b0);
        check("r_done",  done,          1'b0);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("r_done2", done, 1'b0);

        run_job(2'd0, 3'd1, 0, 1'b0);
        check("d_beats", beats.size(), 8);
        for (int k = 0; k < 8; k++)
            check($sformatf("d_beat%0d", k), beat_at(k), exp_vec(gold1[k][0], gold1[k][1], gold1[k][2], gold1[k][3]));
        check("d_done_k", done_k, 10);

        // start held high through the whole job and the final handshake
        run_job(2'd0, 3'd1, 0, 1'b1);
        check("e_beats",    beats.size(), 8);
        check("e_done_cnt", done_cnt,     1);
        check("e_last_beat", beat_at(7), exp_vec(0, 0, 0, 0));
        check("e_busy_end", busy,          1'b0);
        check("e_valid_end", bus.out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mat_diag_streamer.md
Name: mat_diag_streamer

Overview:
- Read-side sequencer directly downstream of the matrix cache.
- Walks the cache's diagonal read mode across N consecutive cached matrices and streams skewed anti-diagonal vectors to the systolic matrix unit through a valid/ready interface.
- Consecutive matrices overlap: the right half of matrix n and the left half of matrix n+1 go out in the same beat.
- Masks lanes that have no source matrix, so the stream starts and ends with zero-filled skew.

Parameters:
- WIDTH, 128, vector lanes / matrix dimension.
- WIDTH_ADDR_SIZE, 1+$clog2(WIDTH), width of the cache read_param field.
- CACHE_SIZE, 4, matrices held in the cache.
- CACHE_ADDR_SIZE, $clog2(CACHE_SIZE), cache slot address width.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- start  in  1  begin a job; sampled only in IDLE.
- base_addr  in  CACHE_ADDR_SIZE  first cache slot of the job.
- count  in  CACHE_ADDR_SIZE+1  number of matrices, 0..CACHE_SIZE.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the last beat is accepted.
- read_enable  out  1  drives the cache read_enable.
- read_type  out  MatCacheReadOp_t  tied to MAT_CACHE_READ_DIAG.
- read_addr1  out  CACHE_ADDR_SIZE  drives the cache read_addr1.
- read_addr2  out  CACHE_ADDR_SIZE  drives the cache read_addr2.
- read_param  out  WIDTH_ADDR_SIZE  drives the cache read_param.
- cache_data  in  shortreal[WIDTH]  cache data_out (combinational read).
- out_data  out  shortreal[WIDTH]  registered, masked diagonal vector.
- out_valid  out  1  out_data holds a beat.
- out_ready  in  1  consumer accepts the beat.
- out_last  out  1  qualifies the final beat of the job.

Behaviour:
- Reset values: state IDLE; busy, done, out_valid, out_last, read_enable all 0; out_data all 0.0; counters 0.
- Reset mid-job aborts the job immediately: no done pulse, any held beat is discarded.
- States:
  - IDLE: start with count>0 latches base_addr and count, sets n=0, p=0, goes to STREAM. start with count==0 pulses done next cycle, stays IDLE, emits no beats. start while not IDLE is ignored.
  - STREAM: issues one read per "advance" cycle.
    - advance = !out_valid | out_ready.
    - read_enable = advance.
    - read_param = p.
    - read_addr1 = (base+n) mod CACHE_SIZE.
    - read_addr2 = (base+n-1) mod CACHE_SIZE (wraps; n==0 gives base-1 mod CACHE_SIZE, masked anyway).
  - DRAIN: entered after the final read is captured; waits for the final beat handshake.
- Capture on advance, lane i:
  - out_data[i] = 0.0 if (i<=p && n==N) or (i>p && n==0); otherwise cache_data[i].
  - out_valid <= 1.
  - out_last <= (n==N && p==WIDTH-1).
- Counter advance: p increments; at p==WIDTH-1, p wraps to 0 and n increments.
- After capturing n==N, p==WIDTH-1: go to DRAIN.
- Beats per job: (N+1)*WIDTH, where N is the latched count.
- Advance without a new read (DRAIN, or IDLE) while out_ready is high: out_valid <= 0.
- In DRAIN, the out_valid && out_ready && out_last handshake pulses done in the following cycle and returns to IDLE.
  - A start in that same cycle is ignored; busy stays high until IDLE.
- Latency: start at cycle t gives the first read at t+1 and the first out_valid at t+2.
- Throughput: one beat per cycle while out_ready is held high; no bubbles between matrices.
- Backpressure: out_data, out_last and the counters hold while out_valid && !out_ready; read_enable is 0 in those cycles.
- The cache must not be written to the job's slots while busy (system rule, not checked).

Test Plan:
- WIDTH=4, base=0, count=1, M0[i][j]=10i+j, out_ready=1 -> 8 consecutive beats from t+2.
  - Beat p=0 = {0,0,0,0}... lane0 only = M0[0][0]=0.
  - Beat p=2 = {2,11,20,0}.
  - Beat 5 (n=1,p=1) = {0,0,23,32}.
  - out_last on beat 8; done one cycle later.
- count=2, base=3, CACHE_SIZE=4 -> read_addr1 sequence 3,0,1 and read_addr2 2,3,0.
  - Beats 5-8 mix M[0] left half and M[3] right half.
  - 12 beats total.
- out_ready toggles 1,0,0,1 repeating -> out_data stable while stalled.
  - No beat lost or duplicated: bench compares the full sequence against the count=1 golden.
- start with count=0 -> no out_valid; done pulses exactly one cycle later; busy stays 0.
- reset asserted mid-STREAM (beat 3, out_valid=1, out_ready=0) -> next cycle: out_valid=0, busy=0, no done.
  - A fresh start then produces the full golden sequence.
- start held high during a job and on the done cycle -> ignored; exactly one job's beats observed.
